// File: rtl/lsu_mem_stage_if.sv
// rtl/lsu_mem_stage_if.sv - single-port data-memory bus between the LSU stage and memory
interface lsu_mem_stage_if #(
    parameter int D_WIDTH = 32
);
    logic               mem_req;
    logic               mem_we;
    logic [D_WIDTH-1:0] mem_addr;
    logic [D_WIDTH-1:0] mem_wdata;
    logic [3:0]         mem_be;
    logic               mem_ready;
    logic [D_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - LSU memory stage with lane steering and load extension; LSU_MISALIGN_TRAP_EN traps misaligned accesses
module lsu_mem_stage #(
    parameter int D_WIDTH = 32,
    parameter int RD_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [D_WIDTH-1:0] ex_alu_result,
    input  logic [D_WIDTH-1:0] ex_store_data,
    input  logic [2:0]         ex_funct3,
    input  logic               ex_mem_read,
    input  logic               ex_mem_write,
    input  logic [RD_W-1:0]    ex_rd,
    input  logic               ex_reg_write,
    lsu_mem_stage_if.master    bus,
    output logic               wb_valid,
    output logic [RD_W-1:0]    wb_rd,
    output logic               wb_reg_write,
    output logic [D_WIDTH-1:0] wb_data,
    output logic               misalign_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [D_WIDTH-1:0] addr_q, addr_d;
    logic [D_WIDTH-1:0] sdata_q, sdata_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [RD_W-1:0]    rd_q, rd_d;
    logic               reg_write_q, reg_write_d;
    logic               we_q, we_d;

    logic               wb_valid_q, wb_valid_d;
    logic               wb_reg_write_q, wb_reg_write_d;
    logic [RD_W-1:0]    wb_rd_q, wb_rd_d;
    logic [D_WIDTH-1:0] wb_data_q, wb_data_d;

    logic               ex_fire;
    logic               ex_is_mem;
    logic               ex_misaligned;
    logic               req;
    logic [1:0]         off;
    logic [3:0]         be_lanes;
    logic [D_WIDTH-1:0] wdata_lanes;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [D_WIDTH-1:0] load_data;

    // Accept only in IDLE, and never while reset is asserted.
    assign ex_ready  = (state_q == S_IDLE) && !rst;
    assign ex_fire   = ex_valid && ex_ready;
    // Read+write together is handled as a store (we follows ex_mem_write).
    assign ex_is_mem = ex_mem_read || ex_mem_write;
    assign off       = addr_q[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    // Halfwords need addr[0]=0; words (and the reserved size) need addr[1:0]=00.
    always_comb begin
        ex_misaligned = 1'b0;
        if (ex_funct3[1:0] == 2'b01) begin
            ex_misaligned = ex_alu_result[0];
        end else if (ex_funct3[1]) begin
            ex_misaligned = |ex_alu_result[1:0];
        end
    end

    assign misalign_err = misalign_q;
`else
    assign ex_misaligned = 1'b0;
    assign misalign_err  = 1'b0;
`endif

    // Next-state and latch control for the IDLE/ACCESS/DONE sequence.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        sdata_d        = sdata_q;
        funct3_d       = funct3_q;
        rd_d           = rd_q;
        reg_write_d    = reg_write_q;
        we_d           = we_q;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (ex_fire) begin
                    if (!ex_is_mem) begin
                        wb_valid_d     = 1'b1;
                        wb_reg_write_d = ex_reg_write;
                        wb_rd_d        = ex_rd;
                        wb_data_d      = ex_alu_result;
                    end else if (ex_misaligned) begin
                        // Trap: skip the bus, report the faulting address.
                        state_d    = S_DONE;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = ex_rd;
                        wb_data_d  = ex_alu_result;
`ifdef LSU_MISALIGN_TRAP_EN
                        misalign_d = 1'b1;
`endif
                    end else begin
                        state_d     = S_ACCESS;
                        addr_d      = ex_alu_result;
                        sdata_d     = ex_store_data;
                        funct3_d    = ex_funct3;
                        rd_d        = ex_rd;
                        reg_write_d = ex_reg_write;
                        we_d        = ex_mem_write;
                    end
                end
            end
            S_ACCESS: begin
                if (bus.mem_ready) begin
                    state_d        = S_DONE;
                    wb_valid_d     = 1'b1;
                    wb_rd_d        = rd_q;
                    wb_reg_write_d = reg_write_q && !we_q;
                    if (!we_q) begin
                        wb_data_d = load_data;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Store byte enables and lane-replicated write data from the latched op.
    always_comb begin
        be_lanes    = 4'b1111;
        wdata_lanes = sdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                be_lanes    = 4'b0001 << off;
                wdata_lanes = {4{sdata_q[7:0]}};
            end
            2'b01: begin
                be_lanes    = 4'b0011 << {off[1], 1'b0};
                wdata_lanes = {2{sdata_q[15:0]}};
            end
            default: begin
                be_lanes    = 4'b1111;
                wdata_lanes = sdata_q;
            end
        endcase
    end

    // Lane select and sign/zero extension of read data; halfwords use off[1] only.
    always_comb begin
        case (off)
            2'b00:   byte_sel = bus.mem_rdata[7:0];
            2'b01:   byte_sel = bus.mem_rdata[15:8];
            2'b10:   byte_sel = bus.mem_rdata[23:16];
            default: byte_sel = bus.mem_rdata[31:24];
        endcase
        half_sel = off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (funct3_q[1:0])
            2'b00:   load_data = {{(D_WIDTH-8){byte_sel[7] & ~funct3_q[2]}}, byte_sel};
            2'b01:   load_data = {{(D_WIDTH-16){half_sel[15] & ~funct3_q[2]}}, half_sel};
            default: load_data = bus.mem_rdata;
        endcase
    end

    // Bus is driven only in ACCESS; everything reads 0 otherwise, including during reset.
    assign req           = (state_q == S_ACCESS);
    assign bus.mem_req   = req;
    assign bus.mem_we    = req && we_q;
    assign bus.mem_addr  = req ? {addr_q[D_WIDTH-1:2], 2'b00} : '0;
    assign bus.mem_be    = req ? be_lanes : 4'b0000;
    assign bus.mem_wdata = req ? wdata_lanes : '0;

    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;

    // State and data registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            sdata_q        <= '0;
            funct3_q       <= '0;
            rd_q           <= '0;
            reg_write_q    <= 1'b0;
            we_q           <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            sdata_q        <= sdata_d;
            funct3_q       <= funct3_d;
            rd_q           <= rd_d;
            reg_write_q    <= reg_write_d;
            we_q           <= we_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q     <= misalign_d;
`endif
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - randomized self-checking bench for lsu_mem_stage
module tb_lsu_mem_stage;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [2:0]  ex_funct3;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        misalign_err;

    int n_pass  = 0;
    int n_total = 0;

    lsu_mem_stage_if #(.D_WIDTH(32)) bus ();

    lsu_mem_stage #(.D_WIDTH(32), .RD_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data),
        .ex_funct3    (ex_funct3),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .bus          (bus),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .wb_data      (wb_data),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic m_misaligned(input logic [2:0] f3, input logic [31:0] a);
        return TRAP_EN && ((f3[1:0] == 2'b01 && a[0]) || (f3[1] && a[1:0] != 2'b00));
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        if (f3[1:0] == 2'b00) return 4'(1 << int'(a[1:0]));
        if (f3[1:0] == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        if (f3[1:0] == 2'b00) return {24'h0, sd[7:0]} * 32'h0101_0101;
        if (f3[1:0] == 2'b01) return {16'h0, sd[15:0]} * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
        logic [31:0] v;
        int sh;
        if (f3[1:0] == 2'b00) begin
            sh = 8 * int'(a[1:0]);
            v  = (rdata >> sh) & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (f3[1:0] == 2'b01) begin
            sh = a[1] ? 16 : 0;
            v  = (rdata >> sh) & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    task automatic idle_inputs();
        ex_valid      = 1'b0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_funct3     = 3'b000;
        ex_alu_result = 32'h0;
        ex_store_data = 32'h0;
        ex_rd         = 5'd0;
        ex_reg_write  = 1'b0;
    endtask

    task automatic present(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                           input logic rw);
        ex_valid      = 1'b1;
        ex_mem_read   = rd_op;
        ex_mem_write  = wr_op;
        ex_funct3     = f3;
        ex_alu_result = a;
        ex_store_data = sd;
        ex_rd         = rd;
        ex_reg_write  = rw;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        idle_inputs();
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({ex_ready, bus.mem_req, bus.mem_we, bus.mem_be, wb_valid, wb_reg_write, misalign_err} !== 9'b0)
            $display("FAIL reset_ctl: ex_ready=%b req=%b we=%b be=%b wb_valid=%b wb_rw=%b err=%b expected all 0",
                     ex_ready, bus.mem_req, bus.mem_we, bus.mem_be, wb_valid, wb_reg_write, misalign_err);
        else n_pass++;
        n_total++;
        if ({bus.mem_addr, bus.mem_wdata, wb_data, wb_rd} !== 101'b0)
            $display("FAIL reset_data: addr=%h wdata=%h wb_data=%h wb_rd=%0d expected 0",
                     bus.mem_addr, bus.mem_wdata, wb_data, wb_rd);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (ex_ready !== 1'b1) $display("FAIL reset_release: ex_ready=%b expected 1", ex_ready);
        else n_pass++;
        step();
    endtask

    task automatic test_passthrough();
        present(1'b0, 1'b0, 3'b010, 32'h0000_002A, 32'h0, 5'd5, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c < 3) begin
                n_total++;
                if (ex_ready !== 1'b1) $display("FAIL pass_ready%0d: ex_ready=%b expected 1", c, ex_ready);
                else n_pass++;
            end
            if (c >= 1) begin
                n_total++;
                if ({wb_valid, wb_reg_write, wb_rd, wb_data} !== {1'b1, 1'b1, 5'd5, 32'h2A})
                    $display("FAIL pass_wb%0d: valid=%b rw=%b rd=%0d data=%h expected 1 1 5 0000002a",
                             c, wb_valid, wb_reg_write, wb_rd, wb_data);
                else n_pass++;
            end
            step();
            if (c == 2) idle_inputs();
        end
        @(negedge clk);
        n_total++;
        if (wb_valid !== 1'b0) $display("FAIL pass_end: wb_valid=%b expected 0", wb_valid);
        else n_pass++;
        step();
    endtask

    task automatic test_store_byte();
        present(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 5'd3, 1'b1);
        @(negedge clk);
        n_total++;
        if (ex_ready !== 1'b1) $display("FAIL sb_accept: ex_ready=%b expected 1", ex_ready);
        else n_pass++;
        step();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            bus.mem_ready = (i == 1);
            @(negedge clk);
            n_total++;
            if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata, ex_ready} !==
                {1'b1, 1'b1, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 1'b0})
                $display("FAIL sb_bus%0d: req=%b we=%b addr=%h be=%b wdata=%h ex_ready=%b expected 1 1 00001000 1000 abababab 0",
                         i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata, ex_ready);
            else n_pass++;
            step();
        end
        bus.mem_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if ({wb_valid, wb_reg_write, bus.mem_req, ex_ready} !== 4'b1000)
            $display("FAIL sb_wb: valid=%b rw=%b req=%b ex_ready=%b expected 1 0 0 0",
                     wb_valid, wb_reg_write, bus.mem_req, ex_ready);
        else n_pass++;
        step();
        @(negedge clk);
        n_total++;
        if ({wb_valid, ex_ready} !== 2'b01)
            $display("FAIL sb_idle: wb_valid=%b ex_ready=%b expected 0 1", wb_valid, ex_ready);
        else n_pass++;
        step();
    endtask

    task automatic test_load_half();
        logic [2:0]  f3s  [2] = '{3'b001, 3'b101};
        logic [31:0] exps [2] = '{32'hFFFF_8001, 32'h0000_8001};
        for (int k = 0; k < 2; k++) begin
            present(1'b1, 1'b0, f3s[k], 32'h0000_2002, 32'h0, 5'd7, 1'b1);
            step();
            idle_inputs();
            bus.mem_ready = 1'b1;
            bus.mem_rdata = 32'h8001_1234;
            @(negedge clk);
            n_total++;
            if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be} !== {1'b1, 1'b0, 32'h0000_2000, 4'b1100})
                $display("FAIL lh_bus%0d: req=%b we=%b addr=%h be=%b expected 1 0 00002000 1100",
                         k, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be);
            else n_pass++;
            step();
            bus.mem_ready = 1'b0;
            @(negedge clk);
            n_total++;
            if ({wb_valid, wb_reg_write, wb_rd, wb_data} !== {1'b1, 1'b1, 5'd7, exps[k]})
                $display("FAIL lh_wb%0d: valid=%b rw=%b rd=%0d data=%h expected 1 1 7 %h",
                         k, wb_valid, wb_reg_write, wb_rd, wb_data, exps[k]);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_back_to_back();
        present(1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'h1122_3344, 5'd1, 1'b0);
        step();
        present(1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd9, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = (i == 3);
            @(negedge clk);
            n_total++;
            if ({ex_ready, bus.mem_req, bus.mem_wdata, bus.mem_be} !== {1'b0, 1'b1, 32'h1122_3344, 4'b1111})
                $display("FAIL bp_hold%0d: ex_ready=%b req=%b wdata=%h be=%b expected 0 1 11223344 1111",
                         i, ex_ready, bus.mem_req, bus.mem_wdata, bus.mem_be);
            else n_pass++;
            step();
        end
        bus.mem_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if ({wb_valid, wb_reg_write, ex_ready} !== 3'b100)
            $display("FAIL bp_first_wb: valid=%b rw=%b ex_ready=%b expected 1 0 0", wb_valid, wb_reg_write, ex_ready);
        else n_pass++;
        step();
        @(negedge clk);
        n_total++;
        if ({ex_ready, wb_valid} !== 2'b10)
            $display("FAIL bp_accept: ex_ready=%b wb_valid=%b expected 1 0", ex_ready, wb_valid);
        else n_pass++;
        step();
        idle_inputs();
        @(negedge clk);
        n_total++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd9, 32'h55})
            $display("FAIL bp_second_wb: valid=%b rd=%0d data=%h expected 1 9 00000055", wb_valid, wb_rd, wb_data);
        else n_pass++;
        step();
    endtask

    task automatic test_reset_mid_access();
        present(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd4, 1'b1);
        step();
        idle_inputs();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if (bus.mem_req !== 1'b1) $display("FAIL rm_req: req=%b expected 1", bus.mem_req);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if ({bus.mem_req, bus.mem_addr, wb_valid, ex_ready} !== 35'b0)
            $display("FAIL rm_async: req=%b addr=%h wb_valid=%b ex_ready=%b expected 0 0 0 0",
                     bus.mem_req, bus.mem_addr, wb_valid, ex_ready);
        else n_pass++;
        step();
        bus.mem_ready = 1'b1;
        rst = 1'b0;
        #1;
        n_total++;
        if (ex_ready !== 1'b1) $display("FAIL rm_release: ex_ready=%b expected 1", ex_ready);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if ({wb_valid, bus.mem_req} !== 2'b00)
                $display("FAIL rm_stale%0d: wb_valid=%b req=%b expected 0 0", i, wb_valid, bus.mem_req);
            else n_pass++;
            step();
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_misalign();
        present(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 5'd9, 1'b1);
        step();
        idle_inputs();
        bus.mem_rdata = 32'hCAFE_F00D;
        if (TRAP_EN) begin
            @(negedge clk);
            n_total++;
            if ({bus.mem_req, wb_valid, misalign_err, wb_reg_write, wb_data} !== {4'b0110, 32'h0000_3001})
                $display("FAIL ma_trap: req=%b valid=%b err=%b rw=%b data=%h expected 0 1 1 0 00003001",
                         bus.mem_req, wb_valid, misalign_err, wb_reg_write, wb_data);
            else n_pass++;
            step();
        end else begin
            bus.mem_ready = 1'b1;
            @(negedge clk);
            n_total++;
            if ({bus.mem_req, bus.mem_addr, bus.mem_be} !== {1'b1, 32'h0000_3000, 4'b1111})
                $display("FAIL ma_align: req=%b addr=%h be=%b expected 1 00003000 1111",
                         bus.mem_req, bus.mem_addr, bus.mem_be);
            else n_pass++;
            step();
            bus.mem_ready = 1'b0;
            @(negedge clk);
            n_total++;
            if ({wb_valid, misalign_err, wb_reg_write, wb_data} !== {3'b101, 32'hCAFE_F00D})
                $display("FAIL ma_wb: valid=%b err=%b rw=%b data=%h expected 1 0 1 cafef00d",
                         wb_valid, misalign_err, wb_reg_write, wb_data);
            else n_pass++;
            step();
        end
        @(negedge clk);
        n_total++;
        if ({ex_ready, misalign_err, wb_valid} !== 3'b100)
            $display("FAIL ma_after: ex_ready=%b err=%b valid=%b expected 1 0 0", ex_ready, misalign_err, wb_valid);
        else n_pass++;
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            int          kind;
            int          lat;
            logic [2:0]  f3;
            logic [31:0] a, sd, rdata, exp_data;
            logic [4:0]  rd;
            logic        rw, is_mem, is_st, mis, exp_rw;
            kind   = $urandom_range(0, 3);
            f3     = 3'($urandom_range(0, 7));
            a      = $urandom;
            sd     = $urandom;
            rdata  = $urandom;
            rd     = 5'($urandom_range(0, 31));
            rw     = 1'($urandom_range(0, 1));
            lat    = $urandom_range(1, 3);
            is_mem = (kind != 0);
            is_st  = (kind >= 2);
            mis    = is_mem && m_misaligned(f3, a);
            present(kind == 1 || kind == 3, kind >= 2, f3, a, sd, rd, rw);
            @(negedge clk);
            n_total++;
            if (ex_ready !== 1'b1) $display("FAIL rnd%0d_accept: ex_ready=%b expected 1", n, ex_ready);
            else n_pass++;
            step();
            idle_inputs();
            if (is_mem && !mis) begin
                for (int i = 0; i < lat; i++) begin
                    bus.mem_ready = (i == lat - 1);
                    bus.mem_rdata = (i == lat - 1) ? rdata : $urandom;
                    @(negedge clk);
                    n_total++;
                    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, ex_ready} !==
                        {1'b1, is_st, a & 32'hFFFF_FFFC, m_be(f3, a), 1'b0})
                        $display("FAIL rnd%0d_bus: req=%b we=%b addr=%h be=%b ex_ready=%b expected 1 %b %h %b 0",
                                 n, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, ex_ready,
                                 is_st, a & 32'hFFFF_FFFC, m_be(f3, a));
                    else n_pass++;
                    if (is_st) begin
                        n_total++;
                        if (bus.mem_wdata !== m_wdata(f3, sd))
                            $display("FAIL rnd%0d_wdata: wdata=%h expected %h", n, bus.mem_wdata, m_wdata(f3, sd));
                        else n_pass++;
                    end
                    step();
                end
                bus.mem_ready = 1'b0;
            end
            exp_data = (mis || !is_mem) ? a : m_load(f3, a, rdata);
            exp_rw   = !mis && !is_st && rw;
            @(negedge clk);
            n_total++;
            if ({wb_valid, wb_reg_write, misalign_err, bus.mem_req, ex_ready} !== {1'b1, exp_rw, mis, 1'b0, !is_mem})
                $display("FAIL rnd%0d_wbctl: valid=%b rw=%b err=%b req=%b ex_ready=%b expected 1 %b %b 0 %b",
                         n, wb_valid, wb_reg_write, misalign_err, bus.mem_req, ex_ready, exp_rw, mis, !is_mem);
            else n_pass++;
            if (!is_st || mis) begin
                n_total++;
                if (wb_data !== exp_data)
                    $display("FAIL rnd%0d_wbdata: data=%h expected %h (f3=%b addr=%h rdata=%h)",
                             n, wb_data, exp_data, f3, a, rdata);
                else n_pass++;
            end
            if (!mis) begin
                n_total++;
                if (wb_rd !== rd) $display("FAIL rnd%0d_wbrd: rd=%0d expected %0d", n, wb_rd, rd);
                else n_pass++;
            end
            step();
            if ($urandom_range(0, 3) == 0) step();
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_store_byte();
        test_load_half();
        test_back_to_back();
        test_reset_mid_access();
        test_misalign();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
